mmio_blink_bank: RTL and testbench

MMIO_BLINK_BANK -- requirements
Module: mmio_blink_bank

---
 rtl/mmio_blink_bank_if.sv | 20 ++
 rtl/mmio_blink_bank.sv | 188 ++++++++++++++++++
 tb/tb_mmio_blink_bank.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_blink_bank_if.sv
// Register-slot bus for mmio_blink_bank: select, strobes, 5-bit address and
// 32-bit data in each direction.
interface mmio_blink_bank_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/mmio_blink_bank.sv
// Memory-mapped bank of LED channels; each channel is a square-wave blinker or a
// retriggerable one-shot, timed in ms ticks from one shared prescaler.
module mmio_blink_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int CLK_PER_MS = 100000
) (
  input  logic             clk,
  input  logic             reset,
  mmio_blink_bank_if.slave bus,
  output logic [N_CH-1:0]  led_out
);

  localparam int               PRE_W     = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
  localparam logic [4:0]       A_ENABLE  = 5'd0;
  localparam logic [4:0]       A_MODE    = 5'd1;
  localparam logic [4:0]       A_STATUS  = 5'd2;
  localparam logic [4:0]       A_TRIGGER = 5'd3;
  localparam int               A_HP_BASE = 16;

  logic [PRE_W-1:0] pre_r;
  logic             tick_r;

  logic [N_CH-1:0]  en_r;
  logic [N_CH-1:0]  mode_r;
  logic [CNT_W-1:0] hp_r [N_CH];
  logic [CNT_W-1:0] cnt_r [N_CH];
  logic [N_CH-1:0]  busy_r;
  logic [N_CH-1:0]  led_r;

  logic [CNT_W-1:0] cnt_nx_s [N_CH];
  logic [N_CH-1:0]  busy_nx_s;
  logic [N_CH-1:0]  led_nx_s;

  logic             wr_acc_s;
  logic             wr_en_s;
  logic             wr_mode_s;
  logic             wr_trig_s;
  logic [N_CH-1:0]  wr_hp_s;
  logic [N_CH-1:0]  wdat_ch_s;
  logic [CNT_W-1:0] wdat_hp_s;
  logic [N_CH-1:0]  clr_s;
  logic [N_CH-1:0]  live_s;
  logic [N_CH-1:0]  expire_s;
  logic [31:0]      rd_s;
  logic             unused_s;

  assign unused_s  = ^{bus.read, bus.wr_data};
  assign wdat_ch_s = bus.wr_data[N_CH-1:0];
  assign wdat_hp_s = bus.wr_data[CNT_W-1:0];

  // Free-running ms prescaler; tick_r is high for the one cycle after each wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_r  <= {PRE_W{1'b0}};
      tick_r <= 1'b0;
    end else if (pre_r == PRE_LAST) begin
      pre_r  <= {PRE_W{1'b0}};
      tick_r <= 1'b1;
    end else begin
      pre_r  <= pre_r + PRE_W'(1);
      tick_r <= 1'b0;
    end
  end

  // Register-write address decode.
  always_comb begin
    wr_acc_s  = bus.cs & bus.write;
    wr_en_s   = wr_acc_s && (bus.addr == A_ENABLE);
    wr_mode_s = wr_acc_s && (bus.addr == A_MODE);
    wr_trig_s = wr_acc_s && (bus.addr == A_TRIGGER);
    wr_hp_s   = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      wr_hp_s[i] = wr_acc_s && (bus.addr == 5'(A_HP_BASE + i));
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r   <= {N_CH{1'b0}};
      mode_r <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        hp_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        en_r <= wdat_ch_s;
      end
      if (wr_mode_s) begin
        mode_r <= wdat_ch_s;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (wr_hp_s[i]) begin
          hp_r[i] <= wdat_hp_s;
        end
      end
    end
  end

  // Per-channel next state. Writes outrank the tick; expiry uses >= so an
  // out-of-range count is forced back on the next tick.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_nx_s[i]  = cnt_r[i];
      busy_nx_s[i] = busy_r[i];
      led_nx_s[i]  = led_r[i];
      clr_s[i]     = (wr_en_s && !wdat_ch_s[i]) || wr_mode_s || wr_hp_s[i];
      live_s[i]    = en_r[i] && (hp_r[i] != {CNT_W{1'b0}});
      expire_s[i]  = (cnt_r[i] >= (hp_r[i] - CNT_W'(1)));

      if (clr_s[i] || !live_s[i]) begin
        cnt_nx_s[i]  = {CNT_W{1'b0}};
        busy_nx_s[i] = 1'b0;
        led_nx_s[i]  = 1'b0;
      end else if (wr_trig_s && wdat_ch_s[i] && mode_r[i]) begin
        cnt_nx_s[i]  = {CNT_W{1'b0}};
        busy_nx_s[i] = 1'b1;
        led_nx_s[i]  = 1'b1;
      end else if (!tick_r) begin
        cnt_nx_s[i]  = cnt_r[i];
        busy_nx_s[i] = busy_r[i];
        led_nx_s[i]  = led_r[i];
      end else if (!mode_r[i]) begin
        busy_nx_s[i] = 1'b0;
        if (expire_s[i]) begin
          cnt_nx_s[i] = {CNT_W{1'b0}};
          led_nx_s[i] = ~led_r[i];
        end else begin
          cnt_nx_s[i] = cnt_r[i] + CNT_W'(1);
          led_nx_s[i] = led_r[i];
        end
      end else if (busy_r[i]) begin
        if (expire_s[i]) begin
          cnt_nx_s[i]  = {CNT_W{1'b0}};
          busy_nx_s[i] = 1'b0;
          led_nx_s[i]  = 1'b0;
        end else begin
          cnt_nx_s[i]  = cnt_r[i] + CNT_W'(1);
          busy_nx_s[i] = 1'b1;
          led_nx_s[i]  = 1'b1;
        end
      end else begin
        cnt_nx_s[i]  = {CNT_W{1'b0}};
        busy_nx_s[i] = 1'b0;
        led_nx_s[i]  = 1'b0;
      end
    end
  end

  // Per-channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {N_CH{1'b0}};
      led_r  <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      busy_r <= busy_nx_s;
      led_r  <= led_nx_s;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= cnt_nx_s[i];
      end
    end
  end

  assign led_out = led_r;

  // Zero-latency read mux; TRIGGER and unmapped addresses fall through to 0.
  always_comb begin
    rd_s = 32'd0;
    case (bus.addr)
      A_ENABLE: rd_s = 32'(en_r);
      A_MODE:   rd_s = 32'(mode_r);
      A_STATUS: rd_s = {16'(busy_r), 16'(led_r)};
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          rd_s = (bus.addr == 5'(A_HP_BASE + i)) ? 32'(hp_r[i]) : rd_s;
        end
      end
    endcase
  end

  assign bus.rd_data = rd_s;

endmodule

// File: tb/tb_mmio_blink_bank.sv
// Self-checking bench for mmio_blink_bank: register vector table, hand-built
// timing sequences, and random traffic against a tick-counting reference model.
module tb_mmio_blink_bank;
  localparam int N_CH       = 4;
  localparam int CNT_W      = 16;
  localparam int CLK_PER_MS = 4;

  logic            clk;
  logic            reset;
  logic [N_CH-1:0] led_out;

  mmio_blink_bank_if bus();

  mmio_blink_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .CLK_PER_MS(CLK_PER_MS)) dut (
    .clk(clk), .reset(reset), .bus(bus), .led_out(led_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[13];

  // Reference model: per channel, ticks elapsed since the last restart event.
  bit [3:0] m_en, m_mode;
  int       m_hp[4];
  int       m_ticks[4];
  bit       m_armed[4];
  int       m_edge;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus.addr = a; bus.read = 1'b1;
    #1;
    d = bus.rd_data;
    bus.read = 1'b0;
  endtask

  task automatic high_len(input int ch, output int len, output bit sync_ok);
    logic [31:0] d;
    len = 0; sync_ok = 1'b1;
    while (led_out[ch] === 1'b1 && len < 30) begin
      bus_read(5'd2, d);
      if (d[16+ch] !== led_out[ch]) sync_ok = 1'b0;
      len++;
      cyc();
    end
  endtask

  function automatic logic m_led(int i);
    if (!m_en[i] || m_hp[i] == 0) return 1'b0;
    if (m_mode[i]) return m_armed[i];
    return ((m_ticks[i] / m_hp[i]) % 2) == 1;
  endfunction

  function automatic logic m_busy(int i);
    return m_en[i] && m_hp[i] != 0 && m_mode[i] && m_armed[i];
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 5'd0) r = {28'd0, m_en};
    else if (a == 5'd1) r = {28'd0, m_mode};
    else if (a == 5'd2) begin
      for (int i = 0; i < 4; i++) begin
        r[i] = m_led(i);
        r[16+i] = m_busy(i);
      end
    end else if (a >= 5'd16 && a <= 5'd19) r = 32'(m_hp[int'(a) - 16]);
    return r;
  endfunction

  task automatic m_reset();
    m_en = 4'd0; m_mode = 4'd0; m_edge = 0;
    for (int i = 0; i < 4; i++) begin
      m_hp[i] = 0; m_ticks[i] = 0; m_armed[i] = 1'b0;
    end
  endtask

  task automatic m_step(input bit wr, input logic [4:0] a, input logic [31:0] d);
    bit [3:0] o_en, o_mode;
    int       o_hp[4];
    bit       clr[4];
    bit       trg[4];
    bit       tick;
    o_en = m_en; o_mode = m_mode; o_hp = m_hp;
    m_edge++;
    tick = (m_edge >= CLK_PER_MS + 1) && ((m_edge - 1) % CLK_PER_MS == 0);
    for (int i = 0; i < 4; i++) begin
      clr[i] = 1'b0; trg[i] = 1'b0;
    end
    if (wr) begin
      if (a == 5'd0) begin
        for (int i = 0; i < 4; i++) if (!d[i]) clr[i] = 1'b1;
        m_en = d[3:0];
      end else if (a == 5'd1) begin
        m_mode = d[3:0];
        for (int i = 0; i < 4; i++) clr[i] = 1'b1;
      end else if (a == 5'd3) begin
        for (int i = 0; i < 4; i++) trg[i] = d[i];
      end else if (a >= 5'd16 && a <= 5'd19) begin
        m_hp[int'(a) - 16] = int'(d[15:0]);
        clr[int'(a) - 16] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (clr[i]) begin
        m_ticks[i] = 0; m_armed[i] = 1'b0;
      end else if (o_en[i] && o_hp[i] != 0) begin
        if (trg[i] && o_mode[i]) begin
          m_ticks[i] = 0; m_armed[i] = 1'b1;
        end else if (tick) begin
          if (!o_mode[i]) m_ticks[i]++;
          else if (m_armed[i]) begin
            m_ticks[i]++;
            if (m_ticks[i] >= o_hp[i]) begin
              m_armed[i] = 1'b0; m_ticks[i] = 0;
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  regs[7];
    int          n, len, len2;
    bit          ok, sync_ok, glitch;

    regs = '{5'd0, 5'd1, 5'd2, 5'd16, 5'd17, 5'd18, 5'd19};
    vecs[0]  = '{1'b1, 5'd0,  32'h0000_FFFF, 32'h0000_000F};
    vecs[1]  = '{1'b1, 5'd1,  32'hFFFF_FFF5, 32'h0000_0005};
    vecs[2]  = '{1'b1, 5'd16, 32'h0001_2345, 32'h0000_2345};
    vecs[3]  = '{1'b1, 5'd19, 32'h0000_ABCD, 32'h0000_ABCD};
    vecs[4]  = '{1'b1, 5'd5,  32'h0000_FFFF, 32'h0000_0000};
    vecs[5]  = '{1'b1, 5'd3,  32'h0000_000F, 32'h0000_0000};
    vecs[6]  = '{1'b1, 5'd20, 32'h0000_0077, 32'h0000_0000};
    vecs[7]  = '{1'b0, 5'd31, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{1'b1, 5'd18, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1'b1, 5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{1'b1, 5'd1,  32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{1'b0, 5'd16, 32'h0000_0000, 32'h0000_2345};
    vecs[12] = '{1'b0, 5'd19, 32'h0000_0000, 32'h0000_ABCD};

    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = 5'd0; bus.wr_data = 32'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_led", 32'(led_out), 32'd0);
    for (int k = 0; k < 7; k++) begin
      bus_read(regs[k], d);
      check($sformatf("reset_reg%0d", regs[k]), d, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 13; k++) begin
      if (vecs[k].wr) bus_write(vecs[k].addr, vecs[k].wdata);
      bus_read(vecs[k].addr, d);
      check($sformatf("vec%0d_addr%0d", k, vecs[k].addr), d, vecs[k].exp_rd);
    end

    // Blink on channel 0 with a 3 ms half period: 12 cycles per level.
    bus_write(5'd16, 32'd3);
    bus_write(5'd0, 32'd1);
    n = 0;
    while (led_out[0] !== 1'b1 && n < 40) begin cyc(); n++; end
    check("blink_first_rise", 32'(led_out[0]), 32'd1);
    ok = 1'b1;
    n = 0;
    do begin cyc(); n++; if (led_out[3:1] !== 3'd0) ok = 1'b0; end
    while (led_out[0] === 1'b1 && n < 40);
    check("blink_high_cycles", 32'(n), 32'd12);
    n = 0;
    do begin cyc(); n++; if (led_out[3:1] !== 3'd0) ok = 1'b0; end
    while (led_out[0] === 1'b0 && n < 40);
    check("blink_low_cycles", 32'(n), 32'd12);
    check("blink_other_bits", 32'(ok), 32'd1);
    bus_write(5'd0, 32'd0);
    check("disable_led", 32'(led_out), 32'd0);
    bus_read(5'd2, d);
    check("disable_status", d, 32'd0);

    // One-shot on channel 1, then a retrigger 5 cycles into a second pulse.
    bus_write(5'd1, 32'd2);
    bus_write(5'd17, 32'd2);
    bus_write(5'd0, 32'd2);
    bus_write(5'd3, 32'd2);
    bus_read(5'd2, d);
    check("oneshot_start_status", d, 32'h0002_0002);
    high_len(1, len, sync_ok);
    check("oneshot_len_5to8", 32'(len >= 5 && len <= 8), 32'd1);
    check("oneshot_busy_tracks_led", 32'(sync_ok), 32'd1);
    bus_read(5'd2, d);
    check("oneshot_end_status", d, 32'd0);
    bus_write(5'd3, 32'd2);
    glitch = 1'b0;
    repeat (4) begin cyc(); if (led_out[1] !== 1'b1) glitch = 1'b1; end
    bus_write(5'd3, 32'd2);
    if (led_out[1] !== 1'b1) glitch = 1'b1;
    check("retrigger_no_glitch", 32'(glitch), 32'd0);
    high_len(1, len2, sync_ok);
    check("retrigger_len_5to8", 32'(len2 >= 5 && len2 <= 8), 32'd1);
    check("retrigger_busy_tracks_led", 32'(sync_ok), 32'd1);

    // Zero half period on channel 2: never lights, trigger ignored.
    bus_write(5'd1, 32'd0);
    bus_write(5'd18, 32'd0);
    bus_write(5'd0, 32'd4);
    ok = 1'b1;
    repeat (30) begin cyc(); if (led_out !== 4'd0) ok = 1'b0; end
    check("hp0_blink_dark", 32'(ok), 32'd1);
    bus_write(5'd1, 32'd4);
    bus_write(5'd3, 32'd4);
    ok = 1'b1;
    repeat (10) begin
      bus_read(5'd2, d);
      if (d !== 32'd0 || led_out !== 4'd0) ok = 1'b0;
      cyc();
    end
    check("hp0_trigger_ignored", 32'(ok), 32'd1);

    // Asynchronous reset in the middle of a pulse.
    bus_write(5'd1, 32'd2);
    bus_write(5'd17, 32'd3);
    bus_write(5'd0, 32'd2);
    bus_write(5'd3, 32'd2);
    cyc(); cyc();
    check("pre_reset_pulse", 32'(led_out), 32'd2);
    #2 reset = 1'b0;
    #1 check("async_reset_led", 32'(led_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus_read(regs[k], d);
      check($sformatf("post_reset_reg%0d", regs[k]), d, 32'd0);
    end
    check("post_reset_led", 32'(led_out), 32'd0);

    // Random traffic against the reference model, starting from a fresh reset.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      bit          wr;
      logic [4:0]  a;
      logic [31:0] wd;
      logic [3:0]  mled;
      int          r;
      wr = ($urandom_range(0, 7) == 0);
      wd = 32'd0;
      if (wr) begin
        r = $urandom_range(0, 8);
        if (r == 0) a = 5'd0;
        else if (r == 1) a = 5'd1;
        else if (r == 2 || r == 3) a = 5'd3;
        else if (r <= 7) a = 5'(16 + r - 4);
        else a = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 15)) : 5'($urandom_range(20, 31));
        if (a >= 5'd16) wd = 32'($urandom_range(0, 4)) | ($urandom & 32'hFFFF_0000);
        else wd = $urandom;
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd2;
      end
      bus.cs = wr; bus.write = wr; bus.addr = a; bus.wr_data = wd;
      #1;
      check($sformatf("rand_rd_c%0d_a%0d", c, a), bus.rd_data, m_read(a));
      @(posedge clk);
      m_step(wr, a, wd);
      @(negedge clk);
      for (int i = 0; i < 4; i++) mled[i] = m_led(i);
      check($sformatf("rand_led_c%0d", c), 32'(led_out), 32'(mled));
    end
    bus.cs = 1'b0; bus.write = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
